// File: rtl/issue_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module : issue_scoreboard_if
// Brief  : Decode / execute / writeback bundle for the issue scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
interface issue_scoreboard_if #(
  parameter int CNT_W = 32
);
  logic             dec_valid;
  logic             dec_ready;
  logic [63:0]      dec_pc;
  logic [31:0]      dec_inst;
  logic [4:0]       dec_rs1;
  logic [4:0]       dec_rs2;
  logic             dec_use_rs1;
  logic             dec_use_rs2;
  logic [4:0]       dec_rd;
  logic             dec_wr_rd;
  logic             ex_valid;
  logic             ex_ready;
  logic [63:0]      ex_pc;
  logic [31:0]      ex_inst;
  logic [4:0]       ex_rd;
  logic             ex_wr_rd;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             flush;
  logic [31:0]      busy_vec;
  logic [3:0]       inflight;
  logic [CNT_W-1:0] stall_cnt;
  logic             err_wb_spurious;

  modport master (
    output dec_valid, dec_pc, dec_inst, dec_rs1, dec_rs2, dec_use_rs1,
           dec_use_rs2, dec_rd, dec_wr_rd, ex_ready, wb_valid, wb_rd, flush,
    input  dec_ready, ex_valid, ex_pc, ex_inst, ex_rd, ex_wr_rd, busy_vec,
           inflight, stall_cnt, err_wb_spurious
  );

  modport slave (
    input  dec_valid, dec_pc, dec_inst, dec_rs1, dec_rs2, dec_use_rs1,
           dec_use_rs2, dec_rd, dec_wr_rd, ex_ready, wb_valid, wb_rd, flush,
    output dec_ready, ex_valid, ex_pc, ex_inst, ex_rd, ex_wr_rd, busy_vec,
           inflight, stall_cnt, err_wb_spurious
  );
endinterface
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : issue_scoreboard
// Brief  : One-slot decode-to-execute issue stage with a 32-entry busy table.
// Rev    : 1.0  initial release
// ============================================================================
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 32
) (
  input  wire logic        clk,
  input  wire logic        rst,
  issue_scoreboard_if.slave bus
);

  localparam logic [3:0]       c_max_inflight = 4'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);

  logic             r_ex_valid;
  logic [63:0]      r_ex_pc;
  logic [31:0]      r_ex_inst;
  logic [4:0]       r_ex_rd;
  logic             r_ex_wr_rd;
  logic [31:0]      r_busy;
  logic [3:0]       r_inflight;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_err_wb_spurious;

  logic        w_haz_rs1;
  logic        w_haz_rs2;
  logic        w_haz_waw;
  logic        w_haz_full;
  logic        w_hazard;
  logic        w_ready;
  logic        w_accept;
  logic        w_set;
  logic        w_clr;
  logic        w_spurious;
  logic        w_stall;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;

  // Hazards look only at registered state; a same-cycle writeback is not bypassed.
  assign w_haz_rs1  = bus.dec_use_rs1 && (bus.dec_rs1 != 5'd0) && r_busy[bus.dec_rs1];
  assign w_haz_rs2  = bus.dec_use_rs2 && (bus.dec_rs2 != 5'd0) && r_busy[bus.dec_rs2];
  assign w_haz_waw  = bus.dec_wr_rd && (bus.dec_rd != 5'd0) && r_busy[bus.dec_rd];
  assign w_haz_full = bus.dec_wr_rd && (bus.dec_rd != 5'd0) && (r_inflight == c_max_inflight);
  assign w_hazard   = w_haz_rs1 | w_haz_rs2 | w_haz_waw | w_haz_full;

  assign w_ready  = ~rst & ~bus.flush & ~w_hazard & (~r_ex_valid | bus.ex_ready);
  assign w_accept = bus.dec_valid & w_ready;

  assign w_set      = w_accept && bus.dec_wr_rd && (bus.dec_rd != 5'd0);
  assign w_clr      = ~bus.flush && bus.wb_valid && (bus.wb_rd != 5'd0) && r_busy[bus.wb_rd];
  assign w_spurious = ~bus.flush && bus.wb_valid && (bus.wb_rd != 5'd0) && ~r_busy[bus.wb_rd];
  assign w_stall    = bus.dec_valid & ~w_ready & ~bus.flush;

  assign w_set_mask = w_set ? (32'd1 << bus.dec_rd) : 32'd0;
  assign w_clr_mask = w_clr ? (32'd1 << bus.wb_rd) : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid        <= 1'b0;
      r_ex_pc           <= 64'd0;
      r_ex_inst         <= 32'd0;
      r_ex_rd           <= 5'd0;
      r_ex_wr_rd        <= 1'b0;
      r_busy            <= 32'd0;
      r_inflight        <= 4'd0;
      r_stall_cnt       <= '0;
      r_err_wb_spurious <= 1'b0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + c_cnt_one;
      end
      if (w_spurious) begin
        r_err_wb_spurious <= 1'b1;
      end

      if (bus.flush) begin
        r_ex_valid <= 1'b0;
        r_busy     <= 32'd0;
        r_inflight <= 4'd0;
      end else begin
        if (w_accept) begin
          r_ex_valid <= 1'b1;
          r_ex_pc    <= bus.dec_pc;
          r_ex_inst  <= bus.dec_inst;
          r_ex_rd    <= bus.dec_rd;
          r_ex_wr_rd <= bus.dec_wr_rd;
        end else if (bus.ex_ready) begin
          r_ex_valid <= 1'b0;
        end
        // Set and clear never target the same register: a busy rd blocks accept.
        r_busy     <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;
        r_inflight <= r_inflight + {3'd0, w_set} - {3'd0, w_clr};
      end
    end
  end

  assign bus.dec_ready       = w_ready;
  assign bus.ex_valid        = r_ex_valid;
  assign bus.ex_pc           = r_ex_pc;
  assign bus.ex_inst         = r_ex_inst;
  assign bus.ex_rd           = r_ex_rd;
  assign bus.ex_wr_rd        = r_ex_wr_rd;
  assign bus.busy_vec        = r_busy;
  assign bus.inflight        = r_inflight;
  assign bus.stall_cnt       = r_stall_cnt;
  assign bus.err_wb_spurious = r_err_wb_spurious;

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : tb_issue_scoreboard
// Brief  : Vector table plus slot-payload queue for issue_scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_issue_scoreboard;

  localparam int c_cnt_w = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issue_scoreboard_if #(.CNT_W(c_cnt_w)) bus ();

  issue_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(c_cnt_w)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        dv;
    logic        u1;
    logic [4:0]  rs1;
    logic        u2;
    logic [4:0]  rs2;
    logic        wr;
    logic [4:0]  rd;
    logic        exr;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        fl;
    logic        exp_ready;
    logic [31:0] exp_busy;
    logic [3:0]  exp_infl;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        wr;
  } slot_t;

  int          checks = 0;
  int          errors = 0;
  int          step_no = 0;
  logic [3:0]  m_stall = 4'd0;
  slot_t       q[$];
  vec_t        tbl[32];

  function automatic vec_t mk(logic dv, logic u1, logic [4:0] rs1, logic u2, logic [4:0] rs2,
                              logic wr, logic [4:0] rd, logic exr, logic wbv, logic [4:0] wbrd,
                              logic fl, logic er, logic [31:0] eb, logic [3:0] ei, logic ee);
    vec_t v;
    v = '{dv, u1, rs1, u2, rs2, wr, rd, exr, wbv, wbrd, fl, er, eb, ei, ee};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", nm, step_no, act, exp);
    end
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic apply(input vec_t v);
    slot_t s;
    s.pc   = 64'h8000_0000 + (64'(step_no) << 2);
    s.inst = (32'(step_no) << 12) | 32'h13;
    s.rd   = v.rd;
    s.wr   = v.wr;
    bus.dec_valid   = v.dv;
    bus.dec_pc      = s.pc;
    bus.dec_inst    = s.inst;
    bus.dec_use_rs1 = v.u1;
    bus.dec_rs1     = v.rs1;
    bus.dec_use_rs2 = v.u2;
    bus.dec_rs2     = v.rs2;
    bus.dec_wr_rd   = v.wr;
    bus.dec_rd      = v.rd;
    bus.ex_ready    = v.exr;
    bus.wb_valid    = v.wbv;
    bus.wb_rd       = v.wbrd;
    bus.flush       = v.fl;
    #1;
    chk("dec_ready", 64'(bus.dec_ready), 64'(v.exp_ready));
    chk("ex_valid", 64'(bus.ex_valid), 64'(q.size() != 0));
    if (bus.ex_valid && q.size() != 0) begin
      chk("ex_pc", bus.ex_pc, q[0].pc);
      chk("ex_inst", 64'(bus.ex_inst), 64'(q[0].inst));
      chk("ex_rd", 64'(bus.ex_rd), 64'(q[0].rd));
      chk("ex_wr_rd", 64'(bus.ex_wr_rd), 64'(q[0].wr));
    end
    if (v.fl) q.delete();
    else if (q.size() != 0 && v.exr) void'(q.pop_front());
    if (v.dv && v.exp_ready) q.push_back(s);
    if (v.dv && !v.exp_ready && !v.fl && m_stall != 4'hF) m_stall = m_stall + 4'd1;
    @(posedge clk);
    #1;
    chk("busy_vec", 64'(bus.busy_vec), 64'(v.exp_busy));
    chk("inflight", 64'(bus.inflight), 64'(v.exp_infl));
    chk("err_wb_spurious", 64'(bus.err_wb_spurious), 64'(v.exp_err));
    chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall));
    step_no++;
  endtask

  initial begin
    //            dv u1 rs1 u2 rs2 wr rd exr wbv wbrd fl  rdy busy     infl err
    tbl[0]  = mk(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0,  1, 32'h8,   1, 0);
    tbl[1]  = mk(1, 1, 3, 0, 0, 1, 4, 1, 0, 0, 0,  0, 32'h8,   1, 0);
    tbl[2]  = mk(1, 1, 3, 0, 0, 1, 4, 1, 0, 0, 0,  0, 32'h8,   1, 0);
    tbl[3]  = mk(1, 1, 3, 0, 0, 1, 4, 1, 1, 3, 0,  0, 32'h0,   0, 0);
    tbl[4]  = mk(1, 1, 3, 0, 0, 1, 4, 1, 0, 0, 0,  1, 32'h10,  1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 0,  1, 32'h0,   0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0,  1, 32'h2,   1, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0,  1, 32'h6,   2, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0,  1, 32'hE,   3, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0,  1, 32'h1E,  4, 0);
    tbl[10] = mk(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0,  0, 32'h1E,  4, 0);
    tbl[11] = mk(1, 0, 0, 0, 0, 1, 6, 1, 1, 2, 0,  0, 32'h1A,  3, 0);
    tbl[12] = mk(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0,  1, 32'h5A,  4, 0);
    tbl[13] = mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0,  1, 32'h5A,  4, 0);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h5A,  4, 0);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h5A,  4, 0);
    tbl[16] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 32'h5A,  4, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 32'h5A,  4, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0,  1, 32'h58,  3, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0,  1, 32'h50,  2, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 0,  1, 32'h40,  1, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0,  1, 32'h0,   0, 0);
    tbl[22] = mk(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0,  1, 32'h80,  1, 0);
    tbl[23] = mk(1, 0, 0, 0, 0, 1, 9, 1, 1, 7, 0,  1, 32'h200, 1, 0);
    tbl[24] = mk(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0,  1, 32'h280, 2, 0);
    tbl[25] = mk(1, 0, 0, 0, 0, 1,10, 1, 1, 7, 1,  0, 32'h0,   0, 0);
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1,12, 0,  1, 32'h0,   0, 1);
    tbl[27] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  1, 32'h0,   0, 1);
    tbl[28] = mk(1, 1, 0, 0, 0, 1, 5, 1, 0, 0, 0,  1, 32'h20,  1, 1);
    tbl[29] = mk(1, 0, 0, 1, 5, 0, 0, 1, 0, 0, 0,  0, 32'h20,  1, 1);
    tbl[30] = mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0,  0, 32'h20,  1, 1);
    tbl[31] = mk(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 1,  0, 32'h0,   0, 1);

    bus.dec_valid = 1'b0; bus.dec_pc = '0; bus.dec_inst = '0;
    bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.dec_use_rs1 = 1'b0; bus.dec_use_rs2 = 1'b0;
    bus.dec_rd = '0; bus.dec_wr_rd = 1'b0; bus.ex_ready = 1'b1;
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.flush = 1'b0;

    #1;
    chk("rst dec_ready", 64'(bus.dec_ready), 64'd0);
    chk("rst ex_valid", 64'(bus.ex_valid), 64'd0);
    chk("rst busy_vec", 64'(bus.busy_vec), 64'd0);
    chk("rst inflight", 64'(bus.inflight), 64'd0);
    chk("rst stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("rst err", 64'(bus.err_wb_spurious), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 32; i++) apply(tbl[i]);

    // Stall counter saturation: hold a full slot against a waiting decode.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 1));
    for (int i = 0; i < 10; i++) apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1));
    chk("stall_cnt saturated", 64'(bus.stall_cnt), 64'hF);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0, 0, 1));

    // Reset mid-stream: asynchronous clear with an instruction in flight.
    apply(mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 1, 32'h20, 1, 1));
    bus.dec_valid = 1'b1; bus.dec_wr_rd = 1'b1; bus.dec_rd = 5'd6; bus.ex_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid rst dec_ready", 64'(bus.dec_ready), 64'd0);
    chk("mid rst ex_valid", 64'(bus.ex_valid), 64'd0);
    chk("mid rst ex_pc", bus.ex_pc, 64'd0);
    chk("mid rst ex_inst", 64'(bus.ex_inst), 64'd0);
    chk("mid rst ex_rd", 64'(bus.ex_rd), 64'd0);
    chk("mid rst ex_wr_rd", 64'(bus.ex_wr_rd), 64'd0);
    chk("mid rst busy_vec", 64'(bus.busy_vec), 64'd0);
    chk("mid rst inflight", 64'(bus.inflight), 64'd0);
    chk("mid rst stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("mid rst err", 64'(bus.err_wb_spurious), 64'd0);
    q.delete();
    m_stall = 4'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.dec_valid = 1'b0; bus.dec_wr_rd = 1'b0; bus.dec_rd = 5'd0; bus.ex_ready = 1'b1;
    #1;
    chk("post rst dec_ready", 64'(bus.dec_ready), 64'd1);
    chk("post rst busy_vec", 64'(bus.busy_vec), 64'd0);
    @(posedge clk); #1;
    apply(mk(1, 1, 5, 0, 0, 1, 5, 1, 0, 0, 0, 1, 32'h20, 1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Decode-to-execute issue controller for the in-order core.
- Holds one registered issue slot between decode and execute, and tracks pending register writes in a 32-entry busy scoreboard.
- Stalls decode on RAW/WAW hazards or when the in-flight limit is reached.
- Provides flush on trap/redirect, plus stall statistics and error flags for debug visibility.

Parameters:
- MAX_INFLIGHT, 4, maximum number of issued-but-not-written-back register-writing instructions (1..15).
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous active-high reset
- dec_valid  input  1  decode presents an instruction
- dec_ready  output  1  issue slot accepts the instruction this cycle
- dec_pc  input  64  instruction PC
- dec_inst  input  32  raw instruction
- dec_rs1  input  5  source register 1
- dec_rs2  input  5  source register 2
- dec_use_rs1  input  1  instruction reads rs1
- dec_use_rs2  input  1  instruction reads rs2
- dec_rd  input  5  destination register
- dec_wr_rd  input  1  instruction writes rd
- ex_valid  output  1  issue slot holds a valid instruction
- ex_ready  input  1  execute consumes the slot this cycle
- ex_pc  output  64  registered PC
- ex_inst  output  32  registered instruction
- ex_rd  output  5  registered rd
- ex_wr_rd  output  1  registered write flag
- wb_valid  input  1  writeback retires a register write
- wb_rd  input  5  register being written back
- flush  input  1  trap/redirect: discard slot and scoreboard
- busy_vec  output  32  current scoreboard; bit 0 is always 0
- inflight  output  4  number of pending register writes
- stall_cnt  output  CNT_W  saturating count of stalled decode cycles
- err_wb_spurious  output  1  sticky flag: writeback to a non-busy register

Behaviour:
- Reset (asynchronous, rst=1): all of the following clear to 0 immediately: ex_valid, ex_pc, ex_inst, ex_rd, ex_wr_rd, busy_vec, inflight, stall_cnt, err_wb_spurious. dec_ready is 0 while rst=1.
- Hazard is combinational and uses registered state only. There is no same-cycle writeback bypass.
  - Hazard when dec_use_rs1 && dec_rs1!=0 && busy[dec_rs1].
  - Hazard when dec_use_rs2 && dec_rs2!=0 && busy[dec_rs2].
  - Hazard when dec_wr_rd && dec_rd!=0 && busy[dec_rd] (WAW).
  - Hazard when dec_wr_rd && dec_rd!=0 && inflight==MAX_INFLIGHT.
- dec_ready = ~rst & ~flush & ~hazard & (~ex_valid | ex_ready).
- Accept (dec_valid & dec_ready), on the next edge:
  - ex_* load from dec_*; ex_valid=1.
  - If dec_wr_rd && dec_rd!=0: busy[dec_rd] sets and inflight increments.
  - If dec_rd==0 with dec_wr_rd=1: the instruction still issues with ex_wr_rd=1, but the scoreboard and inflight are unchanged.
- Slot drain: ex_valid & ex_ready & ~accept -> ex_valid=0. Simultaneous drain and accept -> slot replaced, ex_valid stays 1.
- Slot hold: ex_valid & ~ex_ready keeps all ex_* stable.
- Writeback: wb_valid && wb_rd!=0 && busy[wb_rd] -> busy[wb_rd] clears and inflight decrements.
  - wb_rd==0 is ignored.
  - wb_valid to a non-busy nonzero register -> no state change; err_wb_spurious sets and stays set until reset.
- Same-cycle writeback and accept:
  - Both take effect; inflight nets to unchanged when both touch the count.
  - The accepted rd can never equal the cleared wb_rd, because a busy rd blocks accept.
- flush has priority over issue and writeback in the same cycle:
  - Next edge: ex_valid=0, busy_vec=0, inflight=0.
  - err_wb_spurious and stall_cnt are retained.
  - A writeback arriving in the flush cycle is discarded and does not set the error flag.
- stall_cnt increments each cycle with dec_valid & ~dec_ready & ~flush. It saturates at all-ones.
- Invariants:
  - inflight == popcount(busy_vec) at all times.
  - inflight never exceeds MAX_INFLIGHT.
  - busy_vec[0]==0.
- Latency: one cycle from accept to ex_valid. Full throughput of 1 instruction/cycle when there are no hazards and ex_ready=1.

Test Plan:
- Reset mid-stream: issue rd=5, then assert rst for 1 cycle -> all outputs 0 immediately; after deassert, busy_vec=0, dec_ready=1.
- RAW stall: issue rd=3 (addi x3), next instruction use_rs1 rs1=3 -> dec_ready=0 and stall_cnt counts each cycle. Assert wb_valid wb_rd=3 -> dec_ready=1 one cycle later, inflight returns 0.
- In-flight limit, MAX_INFLIGHT=4: issue writes to x1..x4 with ex_ready=1, then a 5th writing x6 -> dec_ready=0. wb x2 -> x6 issues next cycle, busy_vec=0x5A.
- Back-pressure: ex_ready=0 with ex_valid=1 -> dec_ready=0, ex_pc/ex_inst stable. ex_ready=1 together with a valid decode -> slot replaced the same edge, ex_valid stays 1.
- Flush vs writeback: busy x7,x9, assert flush together with wb_valid wb_rd=7 -> busy_vec=0, inflight=0, ex_valid=0, err_wb_spurious=0.
- x0 and spurious writeback: issue rd=0 with wr_rd=1 -> ex_valid=1, busy_vec=0. wb_valid wb_rd=12 while not busy -> err_wb_spurious=1 sticky, no other state change.
